// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   op_e    : RV32M funct3 encodings
//   state_e : control FSM states
//   DIV0_QUOT / INT_MIN : special-case result constants
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 64-bit accumulator datapath for the iterative RV32M unit.
// Multiply: shift-add, acc = {partial_hi, multiplier}, one bit per step.
// Divide:   restoring, acc = {remainder, dividend/quotient}, one bit per step.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   init_i           : load magnitudes and result controls
//   step_i           : perform one iteration
//   is_div_i         : divide (1) or multiply (0)
//   neg_res_i        : negate product / quotient
//   neg_rem_i        : negate remainder
//   sel_hi_i         : select high half (MULH*) or remainder (REM*)
//   a_mag_i, b_mag_i : operand magnitudes
//   result_o         : sign-fixed result of the step in progress
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic            neg_res_i,
  input  logic            neg_rem_i,
  input  logic            sel_hi_i,
  input  logic [XLEN-1:0] a_mag_i,
  input  logic [XLEN-1:0] b_mag_i,
  output logic [XLEN-1:0] result_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              sel_hi_q, sel_hi_d;

  logic [2*XLEN-1:0] step_val;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    sum       = '0;
    if (is_div_q) begin
      // Remainder shifted left is XLEN+1 bits wide; compare at that width.
      if (rem_shift >= {1'b0, b_q}) begin
        step_val = {rem_shift[XLEN-1:0] - b_q, acc_q[XLEN-2:0], 1'b1};
      end else begin
        step_val = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      step_val = {sum, acc_q[XLEN-1:1]};
    end
  end

  // Result is derived from the stepped value so the final iteration's
  // outcome is available in the same cycle the FSM leaves BUSY.
  always_comb begin
    quot = step_val[XLEN-1:0];
    rem  = step_val[2*XLEN-1:XLEN];
    prod = step_val;
    if (neg_res_q) begin
      quot = -step_val[XLEN-1:0];
      prod = -step_val;
    end
    if (neg_rem_q) begin
      rem = -step_val[2*XLEN-1:XLEN];
    end
    if (is_div_q) begin
      result_o = sel_hi_q ? rem : quot;
    end else begin
      result_o = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    sel_hi_d  = sel_hi_q;
    if (init_i) begin
      acc_d     = {{XLEN{1'b0}}, a_mag_i};
      b_d       = b_mag_i;
      is_div_d  = is_div_i;
      neg_res_d = neg_res_i;
      neg_rem_d = neg_rem_i;
      sel_hi_d  = sel_hi_i;
    end else if (step_i) begin
      acc_d = step_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_hi_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      sel_hi_q  <= sel_hi_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for
// MUL/MULH/MULHSU/MULHU; divides are iterative in both builds.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   in_valid_i / in_ready_o   : request handshake
//   op_i                      : RV32M funct3
//   rs1_data_i, rs2_data_i    : operands
//   rd_addr_i                 : destination index
//   flush_i                   : kill in-flight work, drop request
//   out_valid_o / out_ready_i : result handshake
//   out_data_o, out_rd_o      : result and destination index
//   busy_o                    : state is not IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic [4:0]      out_rd_o,
  output logic            busy_o
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [4:0]      out_rd_q, out_rd_d;

  op_e             op;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, sel_hi, div0, ovf;
  logic [XLEN-1:0] special_res;
  logic            core_init, core_step;
  logic [XLEN-1:0] core_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN-1:0]   fast_res;
`endif

  // Operand decode on the request as presented at the input.
  always_comb begin
    op       = op_e'(op_i);
    is_div   = op_i[2];
    a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    b_signed = (op == MULH) || (op == DIV) || (op == REM);
    a_neg    = a_signed && rs1_data_i[XLEN-1];
    b_neg    = b_signed && rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    sel_hi   = is_div ? op_i[1] : (op != MUL);
    div0     = is_div && (rs2_data_i == '0);
    ovf      = ((op == DIV) || (op == REM)) && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
    if (div0) begin
      special_res = op_i[1] ? rs1_data_i : DIV0_QUOT;
    end else begin
      special_res = op_i[1] ? '0 : INT_MIN;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extend to 64 bits; the low 64 bits of the unsigned product equal
  // the two's-complement product for every signedness combination.
  always_comb begin
    a_ext     = {{XLEN{a_signed && rs1_data_i[XLEN-1]}}, rs1_data_i};
    b_ext     = {{XLEN{b_signed && rs2_data_i[XLEN-1]}}, rs2_data_i};
    fast_prod = a_ext * b_ext;
    fast_res  = sel_hi ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
  end
`endif

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .init_i    (core_init),
    .step_i    (core_step),
    .is_div_i  (is_div),
    .neg_res_i (a_neg ^ b_neg),
    .neg_rem_i (a_neg),
    .sel_hi_i  (sel_hi),
    .a_mag_i   (a_mag),
    .b_mag_i   (b_mag),
    .result_o  (core_result)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    core_init   = 1'b0;
    core_step   = 1'b0;
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            out_rd_d = rd_addr_i;
            if (div0 || ovf) begin
              out_data_d  = special_res;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              out_data_d  = fast_res;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
`endif
            else begin
              core_init = 1'b1;
              cnt_d     = '0;
              state_d   = BUSY;
            end
          end
        end
        BUSY: begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            out_data_d  = core_result;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_rd_o    = out_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, self-checking bench for muldiv_unit with a
// behavioural arithmetic model and a per-cycle compare process.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 1;
`else
  localparam int unsigned MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [4:0]  out_rd_o;
  logic        busy_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_rd_o    (out_rd_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Model state: one outstanding request at most.
  bit          pending = 1'b0;
  int unsigned acc_cyc = 0;
  int unsigned exp_lat = 0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_valid;

  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    logic [31:0] r;
    p = 0;
    u = {32'b0, a} * {32'b0, b};
    r = '0;
    case (o)
      MUL:    r = u[31:0];
      MULHU:  r = u[63:32];
      MULH: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r = p[63:32];
      end
      MULHSU: begin
        p = longint'($signed(a)) * longint'({32'b0, b});
        r = p[63:32];
      end
      DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int unsigned model_lat(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    if (o[2] && (b == 0)) return 1;
    if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!o[2]) return MUL_LAT;
    return 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_i) begin
      exp_valid = pending && ((cyc - acc_cyc + 1) >= exp_lat);
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, exp_valid});
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, !pending});
      chk("busy", {31'b0, busy_o}, {31'b0, pending});
      if (exp_valid && out_valid_o) begin
        chk("out_data", out_data_o, exp_data);
        chk("out_rd", {27'b0, out_rd_o}, {27'b0, exp_rd});
      end
    end
  end

  // Called at posedge+1; the request is accepted at the next edge.
  task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op_i       = o;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    pending    = 1'b1;
    acc_cyc    = cyc;
    exp_data   = model_res(o, a, b);
    exp_rd     = rd;
    exp_lat    = model_lat(o, a, b);
  endtask

  task automatic finish(input int unsigned hold, input logic [31:0] lit,
                        input logic [4:0] lit_rd, input int unsigned lit_lat);
    int unsigned n = 0;
    while (!out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid_o) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for out_valid");
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i   = 1'b0;
      pending = 1'b0;
    end else begin
      chk("latency", cyc - acc_cyc + 1, lit_lat);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      chk("lit_data", out_data_o, lit);
      chk("lit_rd", {27'b0, out_rd_o}, {27'b0, lit_rd});
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      out_ready_i = 1'b0;
      pending     = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int unsigned lat;
    int unsigned hold;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs = '{
      '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, MUL_LAT, 0},
      '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, MUL_LAT, 0},
      '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, MUL_LAT, 0},
      '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF, MUL_LAT, 0},
      '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, MUL_LAT, 0},
      '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33, 0},
      '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33, 0},
      '{DIV,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd7,  32'h0000_0006, 33, 0},
      '{REM,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd8,  32'hFFFF_FFFE, 33, 0},
      '{DIVU,   32'd100,       32'd7,         5'd10, 32'h0000_000E, 33, 5},
      '{REMU,   32'd100,       32'd7,         5'd0,  32'h0000_0002, 33, 0},
      '{DIVU,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1, 0},
      '{REMU,   32'd5,         32'd0,         5'd12, 32'h0000_0005, 1, 0},
      '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 5},
      '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1, 0},
      '{DIV,    32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1, 0},
      '{REM,    32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFF9, 1, 0},
      '{DIV,    32'h8000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 33, 0}
    };

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    op_i        = '0;
    rs1_data_i  = '0;
    rs2_data_i  = '0;
    rd_addr_i   = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    chk("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'h1);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_out_data", out_data_o, 32'h0);
    chk("rst_out_rd", {27'b0, out_rd_o}, 32'h0);

    // Back-to-back: each start follows the previous handshake directly.
    foreach (vecs[i]) begin
      chk("model_pin", model_res(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].res);
      start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      finish(vecs[i].hold, vecs[i].res, vecs[i].rd, vecs[i].lat);
    end

    // Flush in BUSY cycle 10, then a new request on the following edge.
    start(DIVU, 32'd1000, 32'd3, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    pending = 1'b0;
    chk("flush_idle", {31'b0, in_ready_o}, 32'h1);
    start(DIVU, 32'd1000, 32'd3, 5'd21);
    finish(0, 32'd333, 5'd21, 33);

    // flush_i together with in_valid_i: no accept.
    op_i       = DIV;
    rs1_data_i = 32'd9;
    rs2_data_i = 32'd3;
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    chk("flush_no_accept", {31'b0, busy_o}, 32'h0);

    // Reset mid-operation clears the data outputs.
    start(REMU, 32'd1000, 32'd7, 5'd22);
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    pending = 1'b0;
    chk("rstmid_out_data", out_data_o, 32'h0);
    chk("rstmid_out_rd", {27'b0, out_rd_o}, 32'h0);
    chk("rstmid_in_ready", {31'b0, in_ready_o}, 32'h1);
    start(REMU, 32'd1000, 32'd7, 5'd22);
    finish(0, 32'd6, 5'd22, 33);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Sits in the execute stage, directly downstream of the register file: it consumes the rs1/rs2 operands read from the register file and returns a 32-bit result plus destination register index to write-back. Operation is multi-cycle behind a valid/ready handshake, and an interrupt/branch flush kills in-flight work.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- in_valid_i  in  1  operation request valid.
- in_ready_o  out  1  unit can accept a request.
- op_i  in  3  RV32M funct3.
- rs1_data_i  in  XLEN  operand A, from register file read port 1.
- rs2_data_i  in  XLEN  operand B, from register file read port 2.
- rd_addr_i  in  5  destination register index.
- flush_i  in  1  kill the current operation; request dropped.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  write-back accepts the result.
- out_data_o  out  XLEN  result.
- out_rd_o  out  5  destination index captured at accept.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready_o=1. Accept on in_valid_i & in_ready_o & !flush_i. Latch op, operands and rd.
- Special cases go IDLE→DONE directly and skip BUSY:
  - DIV/DIVU with divisor 0: quotient = 0xFFFFFFFF.
  - REM/REMU with divisor 0: result = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; the matching REM = 0.
- All other ops: IDLE→BUSY, with a 5-bit iteration counter cleared to 0. Each BUSY cycle performs one shift-add (multiply) or one restoring subtract step (divide). At count 31, go to DONE.
- Signed handling:
  - Magnitudes are taken at accept.
  - Product is negated when exactly one signed-interpreted operand is negative. MULHSU treats only rs1 as signed.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL takes the low 32 bits of the 64-bit product; MULH/MULHSU/MULHU take the high 32 bits.
- DONE: out_valid_o=1. out_data_o and out_rd_o are held stable until out_ready_i. On the handshake, go to IDLE. There is no accept in the same cycle as the handshake.
- flush_i has priority over everything: any state goes to IDLE next cycle, out_valid_o drops, and no result is emitted. flush_i in the same cycle as in_valid_i means no accept.
- rd=x0 is passed through unchanged; the register file discards the write.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_rd_o=0, busy_o=0, state IDLE, counter 0.
- Accept at edge 0. The request is registered, so in_ready_o is low from cycle 1.
- Iterative op: BUSY for cycles 1–32; out_valid_o high from cycle 33.
- Special-case op: out_valid_o high from cycle 1.
- Back-to-back: after the output handshake at edge N, the next accept is possible at edge N+1.
- Reset mid-operation: behaves identically to flush and also clears the data outputs to 0.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 32×32 multiplier and go IDLE→DONE.
  - out_valid_o is high from cycle 1.
- MULDIV_FAST_MUL_EN undefined:
  - Multiplies use the iterative 32-cycle path (result at cycle 33).
  - No hardware multiplier is inferred.
- Divide behaviour is identical in both builds.

## Structure
- Package muldiv_pkg holds:
  - op enum: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - state enum.
  - Constants DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module, muldiv_iter_core: the 64-bit accumulator/remainder datapath with step, init and sign-fixup controls.
- The FSM, handshake and special-case decode stay in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD → out_data_o=0xFFFFFFEB, out_rd_o preserved. Valid at cycle 33, or cycle 1 with MULDIV_FAST_MUL_EN.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. Both valid at cycle 33.
- DIVU 5 / 0 → 0xFFFFFFFF at cycle 1. REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Hold out_ready_i low for 5 cycles after out_valid_o → data and rd stable throughout. Raise it → IDLE next cycle, in_ready_o=1.
- Assert flush_i in BUSY cycle 10 → IDLE next cycle, out_valid_o never asserts, and a new request is accepted the following edge.
